// File: rtl/seg_pkg.sv
// Shared types and constants for the status display arbiter.
package seg_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

    localparam logic [11:0] SEG_DEFAULT_CODE = 12'h100;

    localparam logic [2:0] EN_OFF = 3'b111;
    localparam logic [2:0] EN_D0  = 3'b110;
    localparam logic [2:0] EN_D1  = 3'b101;
    localparam logic [2:0] EN_D2  = 3'b011;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {a,b,c,d,e,f,g,dp}; dp always off.
    localparam logic [7:0] GLYPH [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

endpackage

// File: rtl/seg_status_arbiter_scan.sv
// Digit scanner: prescaler producing the scan tick, digit rotation and glyph lookup.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 262144
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cur_code,
    input  logic        blank,
    output logic [7:0]  seven_seg,
    output logic [2:0]  seven_seg_en,
    output logic        tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    en_q, en_d;
    logic [3:0]    nib;
    logic [2:0]    en_sel;

    assign tick = (pre_q == PW'(SCAN_DIV - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        idx_d = idx_q;
        seg_d = seg_q;
        en_d  = en_q;
        case (idx_q)
            2'd2:    begin nib = cur_code[11:8]; en_sel = EN_D2; end
            2'd1:    begin nib = cur_code[7:4];  en_sel = EN_D1; end
            default: begin nib = cur_code[3:0];  en_sel = EN_D0; end
        endcase
        // cur_code is registered upstream, so a same-cycle change is seen next tick.
        if (tick) begin
            seg_d = GLYPH[nib];
            en_d  = en_sel;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_OFF;
            en_q  <= EN_OFF;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            en_q  <= en_d;
        end
    end

    assign seven_seg    = seg_q;
    assign seven_seg_en = blank ? EN_OFF : en_q;

endmodule

// File: rtl/seg_status_arbiter.sv
// Fixed-priority owner of the 3-digit status display with minimum hold time.
// Optional blinking of the owner's code is enabled by defining SEG_ARB_BLINK_EN.
module seg_status_arbiter
    import seg_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter int          SCAN_DIV     = 262144,
    parameter int          HOLD_TICKS   = 190,
    parameter logic [11:0] DEFAULT_CODE = SEG_DEFAULT_CODE,
    parameter int          BLINK_TICKS  = 95
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*12-1:0]   req_code,
    input  logic [NUM_REQ-1:0]      req_blink,
    output logic [NUM_REQ-1:0]      grant,
    output logic [11:0]             cur_code,
    output logic [7:0]              seven_seg,
    output logic [2:0]              seven_seg_en
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [11:0]         code_q, code_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [NUM_REQ-1:0]  hi_req;
    logic                tick, blank, expired, owner_req, new_grant;

    // Isolates the lowest set bit, i.e. the most severe requester.
    function automatic logic [NUM_REQ-1:0] first(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

    assign expired   = (hold_q == HW'(HOLD_TICKS));
    assign owner_req = |(req & grant_q);
    assign hi_req    = req & (grant_q - NUM_REQ'(1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = first(req);
                    state_d = SHOW;
                end
            end
            SHOW, LINGER: begin
                if (|hi_req) begin
                    grant_d = first(hi_req);
                    state_d = SHOW;
                end else if (owner_req) begin
                    state_d = SHOW;
                end else if (expired) begin
                    grant_d = first(req);
                    state_d = (|req) ? SHOW : IDLE;
                end else begin
                    state_d = LINGER;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        new_grant = (|grant_d) && (grant_d != grant_q);
        if (new_grant)
            hold_d = '0;
        else if (tick && !expired)
            hold_d = hold_q + HW'(1);

        if (state_d == IDLE) begin
            code_d = DEFAULT_CODE;
        end else if (state_d == SHOW) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (grant_d[i]) code_d = req_code[12*i +: 12];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            code_q  <= DEFAULT_CODE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            code_q  <= code_d;
            hold_q  <= hold_d;
        end
    end

`ifdef SEG_ARB_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_TICKS);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        if (tick)
            bcnt_d = (bcnt_q == BW'(2 * BLINK_TICKS - 1)) ? '0 : bcnt_q + BW'(1);
        if (state_d == IDLE)
            blink_d = 1'b0;
        else if (state_d == SHOW || new_grant)
            blink_d = |(req_blink & grant_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
        end
    end

    assign blank = blink_q && (bcnt_q >= BW'(BLINK_TICKS));
`else
    logic unused_blink;
    assign unused_blink = ^{req_blink, BLINK_TICKS[0]};
    assign blank        = 1'b0;
`endif

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk          (clk),
        .rst_n        (rst_n),
        .cur_code     (code_q),
        .blank        (blank),
        .seven_seg    (seven_seg),
        .seven_seg_en (seven_seg_en),
        .tick         (tick)
    );

    assign grant    = grant_q;
    assign cur_code = code_q;

endmodule

// File: tb/tb_seg_status_arbiter.sv
// Directed bench: SCAN_DIV=4 (tick every 4th edge), HOLD_TICKS=3, four requesters.
module tb_seg_status_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*12-1:0] req_code;
    logic [NR-1:0]   req_blink;
    logic [NR-1:0]   grant;
    logic [11:0]     cur_code;
    logic [7:0]      seven_seg;
    logic [2:0]      seven_seg_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [7:0] G0 = 8'b00000011;
    localparam logic [7:0] G1 = 8'b10011111;
    localparam logic [7:0] G5 = 8'b01001001;
    localparam logic [7:0] GE = 8'b01100001;

    seg_status_arbiter #(
        .NUM_REQ    (NR),
        .SCAN_DIV   (4),
        .HOLD_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_code     (req_code),
        .req_blink    (req_blink),
        .grant        (grant),
        .cur_code     (cur_code),
        .seven_seg    (seven_seg),
        .seven_seg_en (seven_seg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges are numbered from the first posedge after reset release.
    task automatic to_edge(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic set_req(input int i, input logic on, input logic [11:0] code);
        req[i] = on;
        req_code[12*i +: 12] = code;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_code = '0; req_blink = '0;
        #12;
        chk("rst_seg",   32'(seven_seg),    32'hFF);
        chk("rst_en",    32'(seven_seg_en), 32'b111);
        chk("rst_grant", 32'(grant),        32'h0);
        chk("rst_code",  32'(cur_code),     32'h100);
        #10 rst_n = 1'b1;

        // Idle scan of the default code 1,0,0
        to_edge(3);
        chk("pre_tick_en", 32'(seven_seg_en), 32'b111);
        to_edge(4);
        chk("idle_en0",  32'(seven_seg_en), 32'b110);
        chk("idle_seg0", 32'(seven_seg),    32'(G0));
        to_edge(8);
        chk("idle_en1",  32'(seven_seg_en), 32'b101);
        chk("idle_seg1", 32'(seven_seg),    32'(G0));
        to_edge(12);
        chk("idle_en2",  32'(seven_seg_en), 32'b011);
        chk("idle_seg2", 32'(seven_seg),    32'(G1));
        chk("idle_grant", 32'(grant),       32'h0);

        // First grant, one cycle of latency
        set_req(2, 1'b1, 12'h5E0);
        to_edge(13);
        chk("g2_grant", 32'(grant),    32'b0100);
        chk("g2_code",  32'(cur_code), 32'h5E0);
        to_edge(16);
        chk("g2_seg0", 32'(seven_seg), 32'(G0));
        to_edge(20);
        chk("g2_seg1", 32'(seven_seg), 32'(GE));
        to_edge(24);
        chk("g2_seg2", 32'(seven_seg), 32'(G5));
        chk("g2_en2",  32'(seven_seg_en), 32'b011);

        // Preemption by req[0]; hold cleared so its drop lingers
        set_req(0, 1'b1, 12'h501);
        to_edge(25);
        chk("pre_grant", 32'(grant),    32'b0001);
        chk("pre_code",  32'(cur_code), 32'h501);
        set_req(0, 1'b0, 12'h777);
        to_edge(26);
        chk("lng_grant", 32'(grant),    32'b0001);
        chk("lng_code",  32'(cur_code), 32'h501);
        to_edge(36);
        chk("lng_hold_grant", 32'(grant), 32'b0001);
        to_edge(37);
        chk("exp_grant", 32'(grant),    32'b0100);
        chk("exp_code",  32'(cur_code), 32'h5E0);

        // req[1] one-cycle pulse; req[3] waits for expiry
        set_req(2, 1'b0, 12'h5E0);
        set_req(1, 1'b1, 12'h0A3);
        to_edge(38);
        chk("r1_grant", 32'(grant),    32'b0010);
        chk("r1_code",  32'(cur_code), 32'h0A3);
        set_req(1, 1'b0, 12'h0A3);
        to_edge(39);
        set_req(3, 1'b1, 12'h3C4);
        chk("r1_lng_code", 32'(cur_code), 32'h0A3);
        to_edge(44);
        chk("r3_wait_grant", 32'(grant), 32'b0010);
        to_edge(48);
        chk("r3_wait_edge", 32'(grant), 32'b0010);
        to_edge(49);
        chk("r3_grant", 32'(grant),    32'b1000);
        chk("r3_code",  32'(cur_code), 32'h3C4);
        set_req(3, 1'b0, 12'h3C4);
        to_edge(60);
        chk("r3_lng_grant", 32'(grant),    32'b1000);
        chk("r3_lng_code",  32'(cur_code), 32'h3C4);
        to_edge(61);
        chk("idle_again_grant", 32'(grant),    32'h0);
        chk("idle_again_code",  32'(cur_code), 32'h100);

        // Asynchronous reset mid-SHOW
        set_req(1, 1'b1, 12'h0A3);
        to_edge(62);
        chk("show_grant", 32'(grant), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant),        32'h0);
        chk("arst_code",  32'(cur_code),     32'h100);
        chk("arst_seg",   32'(seven_seg),    32'hFF);
        chk("arst_en",    32'(seven_seg_en), 32'b111);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant", 32'(grant),    32'b0010);
        chk("post_rst_code",  32'(cur_code), 32'h0A3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
